// File: rtl/rx_cmd_packer.sv
// Packs command-reader response words into fixed-size in-band packets held in two
// ping-pong slots, and serves them word by word to the RX packet mux.
module rx_cmd_packer #(
    parameter int         PKT_WORDS = 256,
    parameter logic [4:0] CMD_CHAN  = 5'h1F
) (
    input  logic        txclk,
    input  logic        reset,
    input  logic [15:0] rx_databus,
    input  logic        rx_WR,
    input  logic        rx_WR_done,
    output logic        rx_WR_enabled,
    input  logic        RD,
    input  logic        RD_done,
    output logic [15:0] dataout,
    output logic        packet_waiting,
    output logic [7:0]  drop_count
);
    localparam int            AW          = $clog2(PKT_WORDS);
    localparam logic [AW-1:0] MAX_PAYLOAD = AW'(PKT_WORDS - 2);
    localparam logic [AW-1:0] LAST_WORD   = AW'(PKT_WORDS - 1);

    logic [15:0] mem [0:2*PKT_WORDS-1];

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_cnt;
    logic               wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
    logic               wr_ovf_q, wr_ovf_d, ovf_now;
    logic [1:0]         slot_full_q, slot_full_d, slot_ovf_q, slot_ovf_d;
    logic [1:0][AW-1:0] slot_len_q, slot_len_d;
    logic               en_q, en_d;
    logic [7:0]         drop_q, drop_d;
    logic               wr_store, wr_drop, close_pkt;
    logic               rd_go, rd_free;
    logic [AW-1:0]      rd_len;
    logic               rd_ovf;
    logic [8:0]         len_bytes;
    logic [15:0]        hdr0, hdr1;
    logic               use_ram_q, use_ram_d;
    logic [15:0]        aux_q, aux_d, ram_rd_q;
    logic [AW:0]        wr_addr, rd_addr;

    // Write side: a word arriving with the close still counts in the length.
    always_comb begin
        wr_store  = rx_WR && en_q && (wr_ptr_q != MAX_PAYLOAD);
        wr_drop   = rx_WR && !wr_store;
        ovf_now   = wr_ovf_q || (rx_WR && en_q && !wr_store);
        wr_cnt    = wr_ptr_q + AW'(wr_store);
        close_pkt = rx_WR_done && en_q && (wr_cnt != '0);
        wr_ptr_d  = close_pkt ? '0 : wr_cnt;
        wr_slot_d = wr_slot_q ^ close_pkt;
        wr_ovf_d  = close_pkt ? 1'b0 : ovf_now;
        drop_d    = drop_q;
        if (wr_drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    assign rd_len    = slot_len_q[rd_slot_q];
    assign rd_ovf    = slot_ovf_q[rd_slot_q];
    assign len_bytes = 9'({rd_len, 1'b0});
    assign hdr0      = {rd_ovf, 6'b0, len_bytes};
    assign hdr1      = {11'b0, CMD_CHAN};

    // Header and padding are synthesized here; only payload comes from the RAM.
    always_comb begin
        rd_go     = RD && packet_waiting && !RD_done;
        rd_free   = (RD_done && packet_waiting) || (rd_go && (rd_ptr_q == LAST_WORD));
        rd_ptr_d  = rd_ptr_q;
        if (rd_free) begin
            rd_ptr_d = '0;
        end else if (rd_go) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        rd_slot_d = rd_slot_q ^ rd_free;
        use_ram_d = use_ram_q;
        aux_d     = aux_q;
        if (rd_go) begin
            use_ram_d = 1'b0;
            aux_d     = 16'h0000;
            if (rd_ptr_q == '0) begin
                aux_d = hdr0;
            end else if (rd_ptr_q == AW'(1)) begin
                aux_d = hdr1;
            end else if ((rd_ptr_q - AW'(2)) < rd_len) begin
                use_ram_d = 1'b1;
            end
        end
    end

    // Close and free always target different slots, so both may land in one cycle.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        assign slot_full_d[gi] = (close_pkt && (wr_slot_q == 1'(gi))) ? 1'b1 :
                                 (rd_free && (rd_slot_q == 1'(gi)))   ? 1'b0 :
                                 slot_full_q[gi];
        assign slot_len_d[gi]  = (close_pkt && (wr_slot_q == 1'(gi))) ? wr_cnt  : slot_len_q[gi];
        assign slot_ovf_d[gi]  = (close_pkt && (wr_slot_q == 1'(gi))) ? ovf_now : slot_ovf_q[gi];
    end

    assign en_d    = !slot_full_d[wr_slot_d];
    assign wr_addr = {wr_slot_q, wr_ptr_q + AW'(2)};
    assign rd_addr = {rd_slot_q, rd_ptr_q};

    always_ff @(posedge txclk) begin
        if (wr_store) begin
            mem[wr_addr] <= rx_databus;
        end
        if (rd_go) begin
            ram_rd_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge txclk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_slot_q   <= 1'b0;
            rd_slot_q   <= 1'b0;
            wr_ovf_q    <= 1'b0;
            slot_full_q <= '0;
            slot_ovf_q  <= '0;
            slot_len_q  <= '0;
            en_q        <= 1'b1;
            drop_q      <= 8'h00;
            use_ram_q   <= 1'b0;
            aux_q       <= 16'h0000;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_slot_q   <= wr_slot_d;
            rd_slot_q   <= rd_slot_d;
            wr_ovf_q    <= wr_ovf_d;
            slot_full_q <= slot_full_d;
            slot_ovf_q  <= slot_ovf_d;
            slot_len_q  <= slot_len_d;
            en_q        <= en_d;
            drop_q      <= drop_d;
            use_ram_q   <= use_ram_d;
            aux_q       <= aux_d;
        end
    end

    assign rx_WR_enabled  = en_q;
    assign packet_waiting = slot_full_q[rd_slot_q];
    assign drop_count     = drop_q;
    assign dataout        = use_ram_q ? ram_rd_q : aux_q;

endmodule
